// File: rtl/serial_to_word.sv
// rtl/serial_to_word.sv - serial bit stream to WIDTH-bit word assembler with two-deep buffering
module serial_to_word #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // EMPTY: output register free; HOLD: output register full;
  // STALL: output register full and a completed word parked in the shift register
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] sr_shift;
  logic             bit_accept;
  logic             last_accept;
  logic             word_consume;

  assign bit_ready    = !rst && (state_q != STALL);
  assign word_valid   = (state_q != EMPTY);
  assign word_out     = word_q;
  assign bit_count    = cnt_q;
  assign bit_accept   = bit_valid && bit_ready;
  assign last_accept  = bit_accept && (cnt_q == LAST_IDX);
  assign word_consume = word_valid && word_ready;

  // State and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decision from last-bit completion and downstream consumption
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (last_accept) state_d = HOLD;
      end
      HOLD: begin
        if (last_accept && !word_consume) state_d = STALL;
        else if (!last_accept && word_consume) state_d = EMPTY;
      end
      STALL: begin
        if (word_consume) state_d = HOLD;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Shift register, bit counter and output register loads
  always_comb begin
    if (MSB_FIRST) sr_shift = {sr_q[WIDTH-2:0], bit_in};
    else           sr_shift = {bit_in, sr_q[WIDTH-1:1]};

    sr_d   = bit_accept ? sr_shift : sr_q;
    cnt_d  = cnt_q;
    word_d = word_q;

    if (bit_accept) begin
      if (cnt_q == LAST_IDX) cnt_d = '0;
      else                   cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      EMPTY: begin
        if (last_accept) word_d = sr_shift;
      end
      HOLD: begin
        // refill in the same cycle as the consume keeps word_valid high with no bubble
        if (last_accept && word_consume) word_d = sr_shift;
      end
      STALL: begin
        if (word_consume) word_d = sr_q;
      end
      default: word_d = word_q;
    endcase
  end

endmodule

// File: tb/tb_serial_to_word.sv
// tb/tb_serial_to_word.sv - randomized self-checking bench for serial_to_word (MSB- and LSB-first)
module tb_serial_to_word;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic word_ready = 1'b0;

  logic         bit_ready_m, word_valid_m, bit_ready_l, word_valid_l;
  logic [W-1:0] word_out_m, word_out_l;
  logic [4:0]   bit_count_m, bit_count_l;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_l[$];
  bit           bits[$];
  int           produced = 0;
  int           consumed = 0;

  always #5 clk = ~clk;

  serial_to_word #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_m),
    .word_out(word_out_m), .word_valid(word_valid_m), .word_ready(word_ready), .bit_count(bit_count_m)
  );

  serial_to_word #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_l),
    .word_out(word_out_l), .word_valid(word_valid_l), .word_ready(word_ready), .bit_count(bit_count_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive at negedge, compare against the model, then advance the model at posedge
  task automatic step(input logic r, input logic bv, input logic bi, input logic wr, output bit acc);
    bit e_ready, e_valid, cons;
    logic [W-1:0] wm, wl;
    @(negedge clk);
    rst = r; bit_valid = bv; bit_in = bi; word_ready = wr;
    #1;
    e_ready = !r && (exp_m.size() < 2);
    e_valid = (exp_m.size() > 0);
    check_eq("bit_ready_m", bit_ready_m, e_ready);
    check_eq("bit_ready_l", bit_ready_l, e_ready);
    check_eq("word_valid_m", word_valid_m, e_valid);
    check_eq("word_valid_l", word_valid_l, e_valid);
    check_eq("bit_count_m", bit_count_m, bits.size());
    check_eq("bit_count_l", bit_count_l, bits.size());
    if (e_valid) begin
      check_eq("word_out_m", word_out_m, exp_m[0]);
      check_eq("word_out_l", word_out_l, exp_l[0]);
    end
    acc  = bv && e_ready;
    cons = e_valid && wr;
    @(posedge clk);
    if (r) begin
      exp_m.delete(); exp_l.delete(); bits.delete();
    end else begin
      if (cons) begin
        void'(exp_m.pop_front());
        void'(exp_l.pop_front());
        consumed++;
      end
      if (acc) begin
        bits.push_back(bi);
        if (bits.size() == W) begin
          wm = '0; wl = '0;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bits[i];
            wl[i]     = bits[i];
          end
          exp_m.push_back(wm);
          exp_l.push_back(wl);
          bits.delete();
          produced++;
        end
      end
    end
  endtask

  task automatic send_bit(input logic bi, input logic wr);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 100) begin
      step(1'b0, 1'b1, bi, wr, acc);
      tries++;
    end
    if (!acc) check_eq("send_bit_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic wr);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], wr);
  endtask

  initial begin
    bit acc;
    logic [W-1:0] w2;
    int cyc;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", word_valid_m, 0);
    check_eq("rst_word", word_out_m, 0);
    check_eq("rst_count", bit_count_m, 0);
    check_eq("rst_ready", bit_ready_m, 0);

    // T1: reset mid-word at bit_count=5
    step(1'b0, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    #1;
    check_eq("t1_count5", bit_count_m, 5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, acc);
    #1;
    check_eq("t1_valid_m", word_valid_m, 0);
    check_eq("t1_word_m", word_out_m, 0);
    check_eq("t1_count_m", bit_count_m, 0);
    check_eq("t1_count_l", bit_count_l, 0);
    send_word(32'h1357_9BDF, 1'b1);
    #1;
    check_eq("t1_fresh_m", word_out_m, 32'h1357_9BDF);
    check_eq("t1_fresh_valid", word_valid_m, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, acc);

    // T2/T3: one word, both bit orders
    send_word(32'hA5C3_0F81, 1'b1);
    #1;
    check_eq("t2_valid", word_valid_m, 1);
    check_eq("t2_word_m", word_out_m, 32'hA5C3_0F81);
    check_eq("t3_word_l", word_out_l, 32'h81F0_C3A5);
    step(1'b0, 1'b0, 1'b0, 1'b1, acc);
    #1;
    check_eq("t2_one_cycle", word_valid_m, 0);

    // T4: backpressure into STALL, then drain two words
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    #1;
    check_eq("t4_hold_word", word_out_m, 32'hDEAD_BEEF);
    check_eq("t4_stall_ready", bit_ready_m, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, 1'b0, 1'b1, acc);
    #1;
    check_eq("t4_second_word", word_out_m, 32'h1234_5678);
    check_eq("t4_second_valid", word_valid_m, 1);
    check_eq("t4_ready_back", bit_ready_m, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, acc);
    #1;
    check_eq("t4_drained", word_valid_m, 0);

    // T5: last bit of word 2 lands together with the consume of word 1
    w2 = 32'h0F0F_3C3C;
    send_word(32'hCAFE_F00D, 1'b0);
    for (int i = W - 1; i >= 1; i--) send_bit(w2[i], 1'b0);
    send_bit(w2[0], 1'b1);
    #1;
    check_eq("t5_valid", word_valid_m, 1);
    check_eq("t5_word_m", word_out_m, w2);
    check_eq("t5_ready", bit_ready_m, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, acc);

    // T6: 1000 random words with random gaps on both sides
    produced = 0;
    consumed = 0;
    cyc = 0;
    while ((produced < 1000 || exp_m.size() > 0) && cyc < 90000) begin
      step(1'b0, (produced < 1000) && ($urandom_range(7) != 0), 1'($urandom_range(1)),
           ($urandom_range(3) != 0), acc);
      cyc++;
    end
    check_eq("t6_produced", produced, 1000);
    check_eq("t6_consumed", consumed, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
